// File: rtl/vram_fetch_if.sv
// Bus bundle between the frame fetch engine, the video SRAM and the video buffer.
// The master side is the fetch engine; the slave side is the SRAM/buffer pair.
interface vram_fetch_if #(
    parameter int AWIDTH = 18,
    parameter int DWIDTH = 8
);
    logic [AWIDTH-1:0] MemAddr;
    logic              MemRd;
    logic [DWIDTH-1:0] MemData;
    logic [DWIDTH-1:0] ByteOut;
    logic              ByteValid;
    logic              BufAlmostFull;

    modport master (
        output MemAddr, MemRd, ByteOut, ByteValid,
        input  MemData, BufAlmostFull
    );

    modport slave (
        input  MemAddr, MemRd, ByteOut, ByteValid,
        output MemData, BufAlmostFull
    );
endinterface

// File: rtl/vram_fetch.sv
// Frame fetch engine: streams one frame of packed pixel bytes from video SRAM
// in address order and hands them to the video buffer as a strobed byte stream.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for FrameStart, no reads outstanding
// FETCH | issuing one read per cycle unless the buffer is almost full
// DRAIN | all reads of the frame issued, waiting for the last bytes
module vram_fetch #(
    parameter int AWIDTH     = 18,
    parameter int DWIDTH     = 8,
    parameter int BASE       = 0,
    parameter int FRAMEBYTES = 230400,
    parameter int MEMLAT     = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           FrameStart,
    output logic           Busy,
    output logic           Late,
    vram_fetch_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One extra bit so the counter can reach FRAMEBYTES = 2^AWIDTH.
    localparam int                CW       = AWIDTH + 1;
    localparam logic [CW-1:0]     LASTCNT  = CW'(FRAMEBYTES - 1);
    localparam logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASE);

    state_t            state;
    logic [CW-1:0]     issueCnt;
    // tokens[0] marks the read currently on the SRAM bus; each following bit
    // is one cycle older. tokens[MEMLAT] means MemData is valid this cycle.
    logic [MEMLAT:0]   tokens;
    logic              pipeEmpty;

    // Drain is complete once no read is anywhere between issue and delivery.
    always_comb begin
        pipeEmpty = (tokens == '0);
    end

    // Sequencer, read issue, token pipeline and byte delivery.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            issueCnt      <= '0;
            tokens        <= '0;
            bus.MemAddr   <= BASEADDR;
            bus.MemRd     <= 1'b0;
            bus.ByteOut   <= '0;
            bus.ByteValid <= 1'b0;
            Busy          <= 1'b0;
            Late          <= 1'b0;
        end else begin
            // Delivery happens regardless of state so restarts in DRAIN keep
            // the old frame's tail intact.
            bus.ByteValid <= tokens[MEMLAT];
            if (tokens[MEMLAT]) begin
                bus.ByteOut <= bus.MemData;
            end
            tokens    <= {tokens[MEMLAT-1:0], 1'b0};
            bus.MemRd <= 1'b0;

            case (state)
                IDLE: begin
                    if (FrameStart) begin
                        issueCnt    <= '0;
                        bus.MemAddr <= BASEADDR;
                        state       <= FETCH;
                        Busy        <= 1'b1;
                    end
                end
                FETCH: begin
                    if (FrameStart) begin
                        // Abort: drop everything in flight, restart the frame.
                        // The byte leaving the pipeline this edge still goes out.
                        Late        <= 1'b1;
                        tokens      <= '0;
                        issueCnt    <= '0;
                        bus.MemAddr <= BASEADDR;
                    end else if (!bus.BufAlmostFull) begin
                        bus.MemRd   <= 1'b1;
                        bus.MemAddr <= BASEADDR + issueCnt[AWIDTH-1:0];
                        tokens      <= {tokens[MEMLAT-1:0], 1'b1};
                        issueCnt    <= issueCnt + 1'b1;
                        if (issueCnt == LASTCNT) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (FrameStart) begin
                        issueCnt <= '0;
                        state    <= FETCH;
                    end else if (pipeEmpty) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
